// File: rtl/dm_if.sv
// -----------------------------------------------------------------------------
// dm_if : memory-stage request/response bundle between the pipeline (master)
//         and the data-memory responder (slave).
//
// Signals
//   req    master->slave  access request
//   we     master->slave  1 = store, 0 = load
//   addr   master->slave  byte address
//   wdata  master->slave  right-justified store data
//   be_op  master->slave  store size (00 none, 01 SW, 10 SH, 11 SB)
//   me_op  master->slave  load type (000 none, 001 LW, 010 LH, 011 LHU,
//                         100 LB, 101 LBU)
//   rdata  slave->master  extended load result, valid while ack=1
//   ack    slave->master  one-cycle completion pulse
//   stall  slave->master  pipeline hold
//   err    slave->master  one-cycle misalignment pulse, coincident with ack
// -----------------------------------------------------------------------------
interface dm_if;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [1:0]  be_op;
   logic [2:0]  me_op;
   logic [31:0] rdata;
   logic        ack;
   logic        stall;
   logic        err;

   modport master (
      output req, we, addr, wdata, be_op, me_op,
      input  rdata, ack, stall, err
   );

   modport slave (
      input  req, we, addr, wdata, be_op, me_op,
      output rdata, ack, stall, err
   );
endinterface

// File: rtl/dm_slave_port.sv
// -----------------------------------------------------------------------------
// dm_slave_port : data-memory responder for the memory stage.
//
// Accepts one load/store at a time, waits WAIT_CYCLES wait states, performs
// the byte/half/word access on an internal 2**AW x 32 array and answers with
// a one-cycle ack. Loads return a sign/zero-extended result in rdata.
//
// Parameters
//   AW           word-address width (array depth 2**AW words)
//   WAIT_CYCLES  wait states between acceptance and response (0..15)
//
// Ports
//   clk    system clock, all state on posedge
//   rst_n  asynchronous active-low reset
//   bus    dm_if.slave : req/we/addr/wdata/be_op/me_op in,
//                        rdata/ack/stall/err out
//
// Build option
//   DM_ALIGN_CHECK_EN  defined  : misaligned half/word accesses raise err with
//                                 ack, stores are dropped, loads return 0.
//                      undefined: err is tied 0 and offending low address
//                                 bits are forced to 0.
// -----------------------------------------------------------------------------
module dm_slave_port #(
   parameter int AW          = 10,
   parameter int WAIT_CYCLES = 2
) (
   input  logic clk,
   input  logic rst_n,
   dm_if.slave  bus
);

   localparam logic [1:0] BE_SW = 2'b01;
   localparam logic [1:0] BE_SH = 2'b10;
   localparam logic [1:0] BE_SB = 2'b11;
   localparam logic [2:0] ME_LW  = 3'b001;
   localparam logic [2:0] ME_LH  = 3'b010;
   localparam logic [2:0] ME_LHU = 3'b011;
   localparam logic [2:0] ME_LB  = 3'b100;
   localparam logic [2:0] ME_LBU = 3'b101;
   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   // Byte-lane write mask for a store of the given size at the given lane.
   function automatic logic [3:0] lane_mask(input logic [1:0] be, input logic [1:0] lane);
      logic [3:0] m;
      case (be)
         BE_SW:   m = 4'b1111;
         BE_SH:   m = lane[1] ? 4'b1100 : 4'b0011;
         BE_SB:   m = 4'b0001 << lane;
         default: m = 4'b0000;
      endcase
      return m;
   endfunction

   // Replicate right-justified store data onto every lane it could land on.
   function automatic logic [31:0] store_lanes(input logic [1:0] be, input logic [31:0] d);
      logic [31:0] r;
      case (be)
         BE_SB:   r = {4{d[7:0]}};
         BE_SH:   r = {2{d[15:0]}};
         default: r = d;
      endcase
      return r;
   endfunction

   // Extract and extend the addressed byte/half/word of a memory word.
   function automatic logic [31:0] load_extend(input logic [2:0] me, input logic [31:0] w,
                                               input logic [1:0] lane);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = w[{lane, 3'b000} +: 8];
      h = lane[1] ? w[31:16] : w[15:0];
      case (me)
         ME_LW:   r = w;
         ME_LH:   r = {{16{h[15]}}, h};
         ME_LHU:  r = {16'h0000, h};
         ME_LB:   r = {{24{b[7]}}, b};
         ME_LBU:  r = {24'h00_0000, b};
         default: r = 32'h0000_0000;
      endcase
      return r;
   endfunction

   state_t          state_r;
   logic [3:0]      cnt_r;
   logic            we_r;
   logic [AW+1:0]   addr_r;
   logic [31:0]     wdata_r;
   logic [1:0]      be_r;
   logic [2:0]      me_r;
   logic [31:0]     rdata_r;
   logic            ack_r;
   logic [31:0]     mem [0:(2**AW)-1];

   logic            take_s;
   logic            commit_s;
   logic            sel_we_s;
   logic [AW+1:0]   sel_addr_s;
   logic [31:0]     sel_wdata_s;
   logic [1:0]      sel_be_s;
   logic [2:0]      sel_me_s;
   logic            is_word_s;
   logic            is_half_s;
   logic            misalign_s;
   logic [1:0]      lane_s;
   logic [AW-1:0]   idx_s;
   logic [31:0]     word_s;
   logic [3:0]      wmask_s;
   logic [31:0]     wlanes_s;
   logic            unused_addr_s;

   assign unused_addr_s = ^bus.addr[31:AW+2];

   // Request acceptance, commit-edge detection and field selection; with zero
   // wait states the commit happens on the accept edge, so use live inputs.
   always_comb begin
      take_s   = (state_r == IDLE) && bus.req;
      commit_s = (take_s && (WAIT_INIT == 4'd0)) ||
                 ((state_r == WAIT) && (cnt_r == 4'd1));
      if (state_r == IDLE) begin
         sel_we_s    = bus.we;
         sel_addr_s  = bus.addr[AW+1:0];
         sel_wdata_s = bus.wdata;
         sel_be_s    = bus.be_op;
         sel_me_s    = bus.me_op;
      end else begin
         sel_we_s    = we_r;
         sel_addr_s  = addr_r;
         sel_wdata_s = wdata_r;
         sel_be_s    = be_r;
         sel_me_s    = me_r;
      end
   end

   // Access size classification, alignment handling and lane/word decode.
   always_comb begin
      if (sel_we_s) begin
         is_word_s = (sel_be_s == BE_SW);
         is_half_s = (sel_be_s == BE_SH);
      end else begin
         is_word_s = (sel_me_s == ME_LW);
         is_half_s = (sel_me_s == ME_LH) || (sel_me_s == ME_LHU);
      end
`ifdef DM_ALIGN_CHECK_EN
      lane_s     = sel_addr_s[1:0];
      misalign_s = (is_word_s && (sel_addr_s[1:0] != 2'b00)) ||
                   (is_half_s && sel_addr_s[0]);
`else
      misalign_s = 1'b0;
      if (is_word_s) begin
         lane_s = 2'b00;
      end else if (is_half_s) begin
         lane_s = {sel_addr_s[1], 1'b0};
      end else begin
         lane_s = sel_addr_s[1:0];
      end
`endif
      idx_s    = sel_addr_s[AW+1:2];
      word_s   = mem[idx_s];
      wmask_s  = lane_mask(sel_be_s, lane_s);
      wlanes_s = store_lanes(sel_be_s, sel_wdata_s);
   end

`ifdef DM_ALIGN_CHECK_EN
   logic err_r;
`endif

   // Control FSM with registered ack/err/rdata; ack follows the commit edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         cnt_r   <= 4'd0;
         we_r    <= 1'b0;
         addr_r  <= '0;
         wdata_r <= 32'h0000_0000;
         be_r    <= 2'b00;
         me_r    <= 3'b000;
         rdata_r <= 32'h0000_0000;
         ack_r   <= 1'b0;
`ifdef DM_ALIGN_CHECK_EN
         err_r   <= 1'b0;
`endif
      end else begin
         ack_r <= commit_s;
`ifdef DM_ALIGN_CHECK_EN
         err_r <= commit_s && misalign_s;
`endif
         if (commit_s && !sel_we_s) begin
            rdata_r <= misalign_s ? 32'h0000_0000 : load_extend(sel_me_s, word_s, lane_s);
         end
         case (state_r)
            IDLE: begin
               if (take_s) begin
                  we_r    <= bus.we;
                  addr_r  <= bus.addr[AW+1:0];
                  wdata_r <= bus.wdata;
                  be_r    <= bus.be_op;
                  me_r    <= bus.me_op;
                  cnt_r   <= WAIT_INIT;
                  state_r <= (WAIT_INIT == 4'd0) ? RESP : WAIT;
               end
            end
            WAIT: begin
               if (cnt_r == 4'd1) begin
                  cnt_r   <= 4'd0;
                  state_r <= RESP;
               end else begin
                  cnt_r <= cnt_r - 4'd1;
               end
            end
            RESP: begin
               state_r <= IDLE;
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   // Word array: lane-masked store on the commit edge; contents are not reset.
   always_ff @(posedge clk) begin
      if (commit_s && sel_we_s && !misalign_s) begin
         for (int i = 0; i < 4; i++) begin
            if (wmask_s[i]) begin
               mem[idx_s][8*i +: 8] <= wlanes_s[8*i +: 8];
            end
         end
      end
   end

   assign bus.rdata = rdata_r;
   assign bus.ack   = ack_r;
   assign bus.stall = take_s || (state_r == WAIT);
`ifdef DM_ALIGN_CHECK_EN
   assign bus.err   = err_r;
`else
   assign bus.err   = 1'b0;
`endif

endmodule
